// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//
// Sequencer for the up_down_counter datapath. A start request runs a
// triangle sweep 0 -> hi_limit -> 0, repeated num_sweeps times, by driving
// the counter's reset and direction pins. The returned count is compared
// every sweep cycle against an internal expected value; any difference
// aborts the run and raises a sticky error.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        run request, sampled only while idle
//   stop         abort an active run
//   hi_limit     sweep peak, latched when start is accepted
//   num_sweeps   number of full up/down sweeps, latched with start
//   busy         high while clearing or sweeping
//   done         one-cycle pulse at the end of every run
//   err          sticky count-mismatch flag
//   sweep_cnt    completed sweeps of the current or last run
//   cnt_rst      drives the counter's rst
//   cnt_up_down  drives the counter's up_down (1 = up)
//   cnt_count    counter's count output

module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   hi_limit,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               cnt_rst,
    output logic               cnt_up_down,
    input  logic [WIDTH-1:0]   cnt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_UP,
        S_DOWN,
        S_FINISH
    } state_t;

    // Registered output bundle; always loaded together with the state it
    // belongs to so the pins line up with the state they describe.
    typedef struct packed {
        logic rst;
        logic up;
        logic busy;
        logic done;
    } drv_t;

    function automatic drv_t drv_of(input state_t s);
        drv_t d;
        d.rst  = 1'b1;
        d.up   = 1'b1;
        d.busy = 1'b0;
        d.done = 1'b0;
        case (s)
            S_CLEAR: d.busy = 1'b1;
            S_UP: begin
                d.rst  = 1'b0;
                d.busy = 1'b1;
            end
            S_DOWN: begin
                d.rst  = 1'b0;
                d.up   = 1'b0;
                d.busy = 1'b1;
            end
            S_FINISH: d.done = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    state_t             state;
    drv_t               drv;
    logic [WIDTH-1:0]   hi_lim;
    logic [SWEEP_W-1:0] num_lim;
    logic [WIDTH-1:0]   exp;
    logic               mismatch;

    assign cnt_rst     = drv.rst;
    assign cnt_up_down = drv.up;
    assign busy        = drv.busy;
    assign done        = drv.done;

    // exp tracks what the counter must show in the current sweep cycle.
    assign mismatch = ((state == S_UP) || (state == S_DOWN)) && (cnt_count != exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drv       <= drv_of(S_IDLE);
            err       <= 1'b0;
            sweep_cnt <= '0;
            hi_lim    <= '0;
            num_lim   <= '0;
            exp       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hi_lim    <= hi_limit;
                        num_lim   <= num_sweeps;
                        err       <= 1'b0;
                        sweep_cnt <= '0;
                        // A zero peak or zero sweep count is a run with no sweep.
                        if ((hi_limit == '0) || (num_sweeps == '0)) begin
                            state <= S_FINISH;
                            drv   <= drv_of(S_FINISH);
                        end else begin
                            state <= S_CLEAR;
                            drv   <= drv_of(S_CLEAR);
                        end
                    end
                end

                S_CLEAR: begin
                    exp <= '0;
                    if (stop) begin
                        state <= S_FINISH;
                        drv   <= drv_of(S_FINISH);
                    end else begin
                        state <= S_UP;
                        drv   <= drv_of(S_UP);
                    end
                end

                S_UP: begin
                    if (mismatch) begin
                        err   <= 1'b1;
                        state <= S_FINISH;
                        drv   <= drv_of(S_FINISH);
                    end else if (stop) begin
                        state <= S_FINISH;
                        drv   <= drv_of(S_FINISH);
                    end else begin
                        exp <= exp + WIDTH'(1);
                        // Turn around on the edge where the counter reaches the peak.
                        if (exp == hi_lim - WIDTH'(1)) begin
                            state <= S_DOWN;
                            drv   <= drv_of(S_DOWN);
                        end
                    end
                end

                S_DOWN: begin
                    if (mismatch) begin
                        err   <= 1'b1;
                        state <= S_FINISH;
                        drv   <= drv_of(S_FINISH);
                    end else if (stop) begin
                        // Partial sweep: sweep_cnt deliberately left alone.
                        state <= S_FINISH;
                        drv   <= drv_of(S_FINISH);
                    end else begin
                        exp <= exp - WIDTH'(1);
                        // Counter returns to 0 on this edge: one sweep complete.
                        if (exp == WIDTH'(1)) begin
                            sweep_cnt <= sweep_cnt + SWEEP_W'(1);
                            if (sweep_cnt + SWEEP_W'(1) == num_lim) begin
                                state <= S_FINISH;
                                drv   <= drv_of(S_FINISH);
                            end else begin
                                state <= S_UP;
                                drv   <= drv_of(S_UP);
                            end
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                    drv   <= drv_of(S_IDLE);
                end

                default: begin
                    state <= S_IDLE;
                    drv   <= drv_of(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl. Contains a behavioural up_down_counter fed
// by the DUT, with an override to inject a wrong count. Expected values for
// every cycle of a run come from closed-form arithmetic on the run length,
// sweep period and the first abort event.

module tb_counter_sweep_ctrl;

    localparam int WIDTH   = 4;
    localparam int SWEEP_W = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   hi_limit;
    logic [SWEEP_W-1:0] num_sweeps;
    logic               busy;
    logic               done;
    logic               err;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               cnt_rst;
    logic               cnt_up_down;
    logic [WIDTH-1:0]   cnt_count;

    logic [WIDTH-1:0]   ctr;
    logic               frc_en;
    logic [WIDTH-1:0]   frc_val;

    int checks;
    int failures;
    int prev_err;
    int prev_sw;

    counter_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .hi_limit    (hi_limit),
        .num_sweeps  (num_sweeps),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sweep_cnt   (sweep_cnt),
        .cnt_rst     (cnt_rst),
        .cnt_up_down (cnt_up_down),
        .cnt_count   (cnt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter the DUT drives.
    always @(posedge clk) begin
        if (cnt_rst)          ctr <= '0;
        else if (cnt_up_down) ctr <= ctr + WIDTH'(1);
        else                  ctr <= ctr - WIDTH'(1);
    end
    assign cnt_count = frc_en ? frc_val : ctr;

    typedef struct {
        int h;
        int n;
        int s;   // stop cycle, 0 = none
        int k;   // forced-mismatch cycle, 0 = none
        int xd;  // expected done cycle
        int xs;  // expected sweep_cnt at done
        int xe;  // expected err at done
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, want);
        end
    endtask

    // Triangle position within a run: cycle 2 is the first sweep cycle.
    function automatic int tri_count(input int h, input int c);
        int t;
        t = (c - 2) % (2 * h);
        if (t < h) return t;
        return 2 * h - t;
    endfunction

    function automatic bit tri_up(input int h, input int c);
        return ((c - 2) % (2 * h)) < h;
    endfunction

    // Sweeps completed before cycle c; l bounds which sweep-end edges count.
    function automatic int sweeps_at(input int h, input int c, input int l);
        int m;
        if (h == 0) return 0;
        m = ((c < l) ? c : l) - 2;
        if (m < 0) return 0;
        return m / (2 * h);
    endfunction

    task automatic idle_cyc();
        start      = 1'b0;
        stop       = 1'($urandom_range(0, 1));
        hi_limit   = WIDTH'($urandom);
        num_sweeps = SWEEP_W'($urandom);
        @(negedge clk);
        chk("idle_busy",   -1, 32'(busy),      32'd0);
        chk("idle_done",   -1, 32'(done),      32'd0);
        chk("idle_cntrst", -1, 32'(cnt_rst),   32'd1);
        chk("idle_count",  -1, 32'(cnt_count), 32'd0);
        chk("idle_err",    -1, 32'(err),       32'(prev_err));
        chk("idle_sweeps", -1, 32'(sweep_cnt), 32'(prev_sw));
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // One run, started in the current cycle (cycle 0). xd < 0 skips the
    // table-supplied end-of-run check.
    task automatic run(input int h, input int n, input int s, input int k,
                       input int xd, input int xs, input int xe);
        int f, e, l, last, ec;
        bit ab, xerr, in_sw, eu;
        ab = 1'b0;
        xerr = 1'b0;
        if (h == 0 || n == 0) begin
            f = 1;
        end else begin
            f = 2 * h * n + 2;
            e = 0;
            if (s >= 1 && s < f) e = s;
            if (k >= 2 && k < f && (e == 0 || k <= e)) begin
                e = k;
                xerr = 1'b1;
            end
            if (e > 0) begin
                f = e + 1;
                ab = 1'b1;
            end
        end
        l = ab ? f - 1 : f;
        last = (xd > f) ? xd : f;

        for (int c = 0; c <= last; c++) begin
            start      = (c == 0) || (c <= f && $urandom_range(0, 3) == 0);
            hi_limit   = (c == 0) ? WIDTH'(h)   : WIDTH'($urandom);
            num_sweeps = (c == 0) ? SWEEP_W'(n) : SWEEP_W'($urandom);
            stop       = (s > 0) && (c == s);
            in_sw      = (c >= 2) && (c < f);
            ec = 0;
            eu = 1'b1;
            if (in_sw) begin
                ec = tri_count(h, c);
                eu = tri_up(h, c);
            end
            frc_en = 1'b0;
            if (in_sw && c == k) begin
                frc_en  = 1'b1;
                frc_val = WIDTH'(ec) ^ WIDTH'($urandom_range(1, 15));
            end

            @(negedge clk);
            chk("busy",    c, 32'(busy),        32'(c >= 1 && c < f));
            chk("done",    c, 32'(done),        32'(c == f));
            chk("cnt_rst", c, 32'(cnt_rst),     32'(!in_sw));
            chk("up_down", c, 32'(cnt_up_down), 32'(eu));
            if (!frc_en && !(c == f && ab))
                chk("count", c, 32'(cnt_count), 32'(ec));
            if (c == 0) begin
                chk("err_held",    c, 32'(err),       32'(prev_err));
                chk("sweeps_held", c, 32'(sweep_cnt), 32'(prev_sw));
            end else begin
                chk("err",    c, 32'(err),       32'((c >= f) ? xerr : 1'b0));
                chk("sweeps", c, 32'(sweep_cnt), 32'(sweeps_at(h, c, l)));
            end
            if (c == xd) begin
                chk("tbl_done",   c, 32'(done),      32'd1);
                chk("tbl_sweeps", c, 32'(sweep_cnt), 32'(xs));
                chk("tbl_err",    c, 32'(err),       32'(xe));
            end
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        stop   = 1'b0;
        frc_en = 1'b0;
        prev_err = int'(xerr);
        prev_sw  = sweeps_at(h, f, l);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev_err = 0;
        prev_sw  = 0;
        ctr      = '0;
        frc_en   = 1'b0;
        frc_val  = '0;
        start    = 1'b0;
        stop     = 1'b0;
        hi_limit = '0;
        num_sweeps = '0;
        rst      = 1'b1;

        tbl[0]  = '{3,  2, 0,  0, 14, 2, 0};
        tbl[1]  = '{1,  1, 0,  0,  4, 1, 0};
        tbl[2]  = '{15, 1, 0,  0, 32, 1, 0};
        tbl[3]  = '{4,  3, 10, 0, 11, 1, 0};
        tbl[4]  = '{4,  1, 0,  3,  4, 0, 1};
        tbl[5]  = '{0,  1, 0,  0,  1, 0, 0};
        tbl[6]  = '{5,  0, 0,  0,  1, 0, 0};
        tbl[7]  = '{2,  2, 1,  0,  2, 0, 0};
        tbl[8]  = '{2,  2, 5,  0,  6, 0, 0};
        tbl[9]  = '{2,  2, 5,  5,  6, 0, 1};
        tbl[10] = '{15, 2, 0,  0, 62, 2, 0};
        tbl[11] = '{1,  3, 0,  0,  8, 3, 0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) idle_cyc();

        // Directed runs, back to back from the first idle cycle.
        for (int i = 0; i < 12; i++)
            run(tbl[i].h, tbl[i].n, tbl[i].s, tbl[i].k, tbl[i].xd, tbl[i].xs, tbl[i].xe);

        // Reset in the middle of the second sweep of an h=1, N=3 run.
        for (int c = 0; c <= 6; c++) begin
            start      = (c == 0);
            hi_limit   = (c == 0) ? WIDTH'(1)   : WIDTH'($urandom);
            num_sweeps = (c == 0) ? SWEEP_W'(3) : SWEEP_W'($urandom);
            rst        = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                chk("pre_rst_busy",   c, 32'(busy),      32'd1);
                chk("pre_rst_sweeps", c, 32'(sweep_cnt), 32'd1);
            end
            if (c == 6) begin
                chk("rst_busy",    c, 32'(busy),        32'd0);
                chk("rst_done",    c, 32'(done),        32'd0);
                chk("rst_err",     c, 32'(err),         32'd0);
                chk("rst_sweeps",  c, 32'(sweep_cnt),   32'd0);
                chk("rst_cntrst",  c, 32'(cnt_rst),     32'd1);
                chk("rst_up_down", c, 32'(cnt_up_down), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        prev_err = 0;
        prev_sw  = 0;

        // Randomised runs with occasional stops and injected mismatches.
        for (int r = 0; r < 40; r++) begin
            int h, n, s, k, f0, g;
            h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            n = int'($urandom_range(0, 3));
            s = 0;
            k = 0;
            if (h > 0 && n > 0) begin
                f0 = 2 * h * n + 2;
                if ($urandom_range(0, 3) == 0) s = int'($urandom_range(1, f0 - 1));
                if ($urandom_range(0, 3) == 0) k = int'($urandom_range(2, f0 - 1));
            end
            run(h, n, s, k, -1, 0, 0);
            g = int'($urandom_range(0, 2));
            for (int i = 0; i < g; i++) idle_cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
